// File: rtl/branch_resolve_queue_if.sv
`default_nettype none
// ============================================================================
// Module : branch_resolve_queue_if
// Brief  : Fetch-push / EX-resolve / pipeline-redirect bundle for the
//          branch resolve queue.
// Rev    : 1.0  initial release
// ============================================================================
interface branch_resolve_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              push_valid;
    logic              push_ready;
    logic              push_taken;
    logic [PC_W-1:0]   push_target;
    logic [PC_W-1:0]   push_fallthru;
    logic              res_valid;
    logic              res_taken;
    logic [PC_W-1:0]   res_target;
    logic              flush;
    logic [PC_W-1:0]   redirect_pc;
    logic              upd_en;
    logic              upd_taken;
    logic [CNT_W-1:0]  count;
    logic              err_underflow;

    modport master (
        output push_valid, push_taken, push_target, push_fallthru,
        output res_valid, res_taken, res_target,
        input  push_ready, flush, redirect_pc, upd_en, upd_taken,
        input  count, err_underflow
    );

    modport slave (
        input  push_valid, push_taken, push_target, push_fallthru,
        input  res_valid, res_taken, res_target,
        output push_ready, flush, redirect_pc, upd_en, upd_taken,
        output count, err_underflow
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module : branch_resolve_queue
// Brief  : In-order queue of predicted branches; compares the head against
//          EX resolution, raises flush/redirect on mispredict.
// Rev    : 1.0  initial release
// ============================================================================
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    branch_resolve_queue_if.slave   bq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    logic              r_taken    [DEPTH];
    logic [PC_W-1:0]   r_target   [DEPTH];
    logic [PC_W-1:0]   r_fallthru [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_flush;
    logic [PC_W-1:0]   r_redirect_pc;
    logic              r_upd_en;
    logic              r_upd_taken;
    logic              r_err_underflow;

    logic              w_push_ready;
    logic              w_push_fire;
    logic              w_push_keep;
    logic              w_res_fire;
    logic              w_mispredict;
    logic              w_head_taken;
    logic [PC_W-1:0]   w_head_target;
    logic [PC_W-1:0]   w_head_fallthru;

    assign w_head_taken    = r_taken[r_rd_ptr];
    assign w_head_target   = r_target[r_rd_ptr];
    assign w_head_fallthru = r_fallthru[r_rd_ptr];

    // No bypass when full: a same-cycle pop does not make room for a push.
    assign w_push_ready = (r_count < c_full) && !r_flush;
    assign w_push_fire  = bq.push_valid && w_push_ready;
    assign w_res_fire   = bq.res_valid && (r_count != '0);
    assign w_mispredict = w_res_fire &&
                          ((bq.res_taken != w_head_taken) ||
                           (bq.res_taken && w_head_taken && (bq.res_target != w_head_target)));
    // A push alongside a mispredict is wrong-path and is dropped.
    assign w_push_keep  = w_push_fire && !w_mispredict;

    always_ff @(posedge clk) begin
        if (w_push_keep) begin
            r_taken[r_wr_ptr]    <= bq.push_taken;
            r_target[r_wr_ptr]   <= bq.push_target;
            r_fallthru[r_wr_ptr] <= bq.push_fallthru;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_flush         <= 1'b0;
            r_redirect_pc   <= '0;
            r_upd_en        <= 1'b0;
            r_upd_taken     <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            r_flush     <= w_mispredict;
            r_upd_en    <= w_res_fire;
            r_upd_taken <= w_res_fire && bq.res_taken;
            if (bq.res_valid && (r_count == '0)) begin
                r_err_underflow <= 1'b1;
            end
            if (w_mispredict) begin
                r_redirect_pc <= bq.res_taken ? bq.res_target : w_head_fallthru;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_count       <= '0;
            end else begin
                if (w_push_keep) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_res_fire) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + CNT_W'(w_push_keep) - CNT_W'(w_res_fire);
            end
        end
    end

    assign bq.push_ready    = w_push_ready;
    assign bq.flush         = r_flush;
    assign bq.redirect_pc   = r_redirect_pc;
    assign bq.upd_en        = r_upd_en;
    assign bq.upd_taken     = r_upd_taken;
    assign bq.count         = r_count;
    assign bq.err_underflow = r_err_underflow;
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_branch_resolve_queue
// Brief  : Directed scenarios plus random traffic against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_branch_resolve_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [31:0] fallthru;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    ent_t        mq[$];
    logic        m_flush = 1'b0;
    logic [31:0] m_redirect = '0;
    logic        m_upd_en = 1'b0;
    logic        m_upd_taken = 1'b0;
    logic        m_err = 1'b0;

    branch_resolve_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bq ();

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bq  (bq.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: queue semantics evaluated from the inputs seen at each edge.
    always @(posedge clk) begin
        ent_t   h;
        ent_t   e;
        logic   ready, push_ok, res_ok, mis;
        if (rst) begin
            mq.delete();
            m_flush = 0; m_redirect = '0; m_upd_en = 0; m_upd_taken = 0; m_err = 0;
        end else begin
            ready   = (mq.size() < DEPTH) && !m_flush;
            push_ok = bq.push_valid && ready;
            res_ok  = bq.res_valid && (mq.size() > 0);
            e.taken = bq.push_taken; e.target = bq.push_target; e.fallthru = bq.push_fallthru;
            if (bq.res_valid && mq.size() == 0) m_err = 1;
            m_upd_en    = res_ok;
            m_upd_taken = res_ok && bq.res_taken;
            m_flush     = 0;
            if (res_ok) begin
                h   = mq[0];
                mis = (h.taken != bq.res_taken) || (bq.res_taken && bq.res_target != h.target);
                if (mis) begin
                    m_flush    = 1;
                    m_redirect = bq.res_taken ? bq.res_target : h.fallthru;
                    mq.delete();
                end else begin
                    void'(mq.pop_front());
                    if (push_ok) mq.push_back(e);
                end
            end else if (push_ok) begin
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",        32'(bq.count), 32'(mq.size()));
            chk("push_ready",   32'(bq.push_ready), 32'((mq.size() < DEPTH) && !m_flush));
            chk("flush",        32'(bq.flush), 32'(m_flush));
            chk("redirect_pc",  bq.redirect_pc, m_redirect);
            chk("upd_en",       32'(bq.upd_en), 32'(m_upd_en));
            chk("upd_taken",    32'(bq.upd_taken), 32'(m_upd_taken));
            chk("err_underflow",32'(bq.err_underflow), 32'(m_err));
        end
    end

    task automatic idle_inputs();
        bq.push_valid = 0; bq.push_taken = 0; bq.push_target = '0; bq.push_fallthru = '0;
        bq.res_valid = 0; bq.res_taken = 0; bq.res_target = '0;
    endtask

    task automatic step(input logic pv, input logic pt, input logic [31:0] ptg,
                        input logic [31:0] pft, input logic rv, input logic rt,
                        input logic [31:0] rtg);
        bq.push_valid = pv; bq.push_taken = pt; bq.push_target = ptg; bq.push_fallthru = pft;
        bq.res_valid = rv; bq.res_taken = rt; bq.res_target = rtg;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic push(input logic t, input logic [31:0] tg, input logic [31:0] ft);
        step(1, t, tg, ft, 0, 0, 0);
    endtask

    task automatic resolve(input logic t, input logic [31:0] tg);
        step(0, 0, 0, 0, 1, t, tg);
    endtask

    initial begin
        int pk;
        int rk;
        idle_inputs();
        rst = 1;
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        rst = 0;
        chk_en = 1;
        chk("reset count", 32'(bq.count), 0);
        chk("reset push_ready", 32'(bq.push_ready), 1);
        chk("reset flush", 32'(bq.flush), 0);
        chk("reset err", 32'(bq.err_underflow), 0);

        // Correct taken stream
        push(1, 32'h100, 32'h44);
        chk("c1 count", 32'(bq.count), 1);
        resolve(1, 32'h100);
        chk("c1 upd_en", 32'(bq.upd_en), 1);
        chk("c1 upd_taken", 32'(bq.upd_taken), 1);
        chk("c1 flush", 32'(bq.flush), 0);
        chk("c1 count0", 32'(bq.count), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("c1 upd_en off", 32'(bq.upd_en), 0);

        // Direction mispredict
        push(0, 32'h200, 32'h84);
        push(1, 32'h300, 32'h90);
        resolve(1, 32'h200);
        chk("dm flush", 32'(bq.flush), 1);
        chk("dm redirect", bq.redirect_pc, 32'h200);
        chk("dm count", 32'(bq.count), 0);
        chk("dm upd_taken", 32'(bq.upd_taken), 1);
        chk("dm push_ready", 32'(bq.push_ready), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("dm flush off", 32'(bq.flush), 0);
        chk("dm redirect hold", bq.redirect_pc, 32'h200);

        // Target mispredict, then not-taken redirect to fallthrough
        push(1, 32'h400, 32'hA4);
        resolve(1, 32'h408);
        chk("tm redirect", bq.redirect_pc, 32'h408);
        step(0, 0, 0, 0, 0, 0, 0);
        push(1, 32'h500, 32'hB4);
        resolve(0, 32'h0);
        chk("nt flush", 32'(bq.flush), 1);
        chk("nt redirect", bq.redirect_pc, 32'hB4);
        chk("nt upd_taken", 32'(bq.upd_taken), 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Full, refused push on pop, then wrap
        for (int i = 0; i < 4; i++) push(1, 32'h1000 + 32'(i), 32'h2000 + 32'(i));
        chk("full count", 32'(bq.count), 4);
        chk("full push_ready", 32'(bq.push_ready), 0);
        step(1, 1, 32'h1004, 32'h2004, 1, 1, 32'h1000);
        chk("full refuse count", 32'(bq.count), 3);
        pk = 4; rk = 1;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 32'h1000 + 32'(pk), 32'h2000 + 32'(pk), 1, 1, 32'h1000 + 32'(rk));
            pk++; rk++;
            chk("wrap flush", 32'(bq.flush), 0);
            chk("wrap count", 32'(bq.count), 3);
        end
        resolve(1, 32'h1000 + 32'(rk));
        chk("pre-mis count", 32'(bq.count), 2);

        // Mispredict with simultaneous push
        step(1, 1, 32'h7000, 32'h7004, 1, 1, 32'hDEAD);
        chk("mp count", 32'(bq.count), 0);
        chk("mp flush", 32'(bq.flush), 1);
        chk("mp redirect", bq.redirect_pc, 32'hDEAD);
        chk("mp push_ready", 32'(bq.push_ready), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("mp dropped", 32'(bq.count), 0);

        // Underflow, then reset during a mispredict
        resolve(1, 32'h10);
        chk("uf err", 32'(bq.err_underflow), 1);
        chk("uf upd_en", 32'(bq.upd_en), 0);
        push(1, 32'h600, 32'hC4);
        push(1, 32'h604, 32'hC8);
        rst = 1;
        resolve(0, 0);
        rst = 0;
        chk("rst flush", 32'(bq.flush), 0);
        chk("rst upd_en", 32'(bq.upd_en), 0);
        chk("rst count", 32'(bq.count), 0);
        chk("rst err", 32'(bq.err_underflow), 0);
        chk("rst redirect", bq.redirect_pc, 0);
        chk("rst push_ready", 32'(bq.push_ready), 1);

        // Random traffic; resolves mostly agree with the head
        for (int i = 0; i < 3000; i++) begin
            logic        rt;
            logic [31:0] rtg;
            rt  = 1'($urandom_range(0, 1));
            rtg = 32'h100 + 32'($urandom_range(0, 1) * 4);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                rt  = mq[0].taken;
                rtg = mq[0].target;
            end
            rst = ($urandom_range(0, 199) == 0);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'h100 + 32'($urandom_range(0, 1) * 4), 32'h800 + 32'($urandom_range(0, 255) * 4),
                 ($urandom_range(0, 2) == 0), rt, rtg);
            rst = 0;
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of in-flight predicted branches; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter PC_W, default 32, meaning the PC width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state SHALL change on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset that is synchronous and active-high.
REQ-005 The block SHALL have port push_valid, input, 1 bit: fetch presents a predicted branch.
REQ-006 The block SHALL have port push_ready, output, 1 bit: the queue accepts a push this cycle.
REQ-007 The block SHALL have port push_taken, input, 1 bit: the predictor's pre_taken for the pushed branch.
REQ-008 The block SHALL have port push_target, input, PC_W bits: the predicted taken target.
REQ-009 The block SHALL have port push_fallthru, input, PC_W bits: the branch PC+4.
REQ-010 The block SHALL have port res_valid, input, 1 bit: EX resolves the oldest outstanding branch.
REQ-011 The block SHALL have port res_taken, input, 1 bit: the actual branch outcome.
REQ-012 The block SHALL have port res_target, input, PC_W bits: the actual taken target.
REQ-013 The block SHALL have port flush, output, 1 bit: registered mispredict pulse to the pipeline.
REQ-014 The block SHALL have port redirect_pc, output, PC_W bits: the correct fetch PC, valid while flush=1.
REQ-015 The block SHALL have port upd_en, output, 1 bit: registered predictor-update strobe, which drives the predictor en.
REQ-016 The block SHALL have port upd_taken, output, 1 bit: the resolved outcome, which drives the predictor real_br_taken.
REQ-017 The block SHALL have port count, output, log2(DEPTH)+1 bits: the number of occupied entries.
REQ-018 The block SHALL have port err_underflow, output, 1 bit: sticky flag set when a resolve arrives on an empty queue.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH entries {taken, target, fallthru}, using read/write pointers that wrap modulo DEPTH.
REQ-020 push_ready SHALL be combinational: push_ready = (count < DEPTH) && !flush.
- There is no full-queue bypass: when count = DEPTH, a push is refused even if a resolve occurs in the same cycle.
REQ-021 A push SHALL be accepted on an edge only when push_valid && push_ready; the entry is written at the write pointer and the write pointer advances.
REQ-022 A resolve SHALL be valid only when res_valid=1 and count>0; it compares the head entry combinationally in the same cycle.
REQ-023 Mispredict SHALL be defined as (res_taken != head.taken) || (res_taken && head.taken && res_target != head.target).
REQ-024 On a correct resolve, the head SHALL be popped; a simultaneous accepted push SHALL also complete, leaving count unchanged.
REQ-025 On a mispredict resolve, at that edge all entries SHALL be discarded, both pointers set equal, and count set to 0.
- Any push in the same cycle SHALL be dropped, because the pushed branch is wrong-path.
REQ-026 On the cycle after a mispredict resolve, flush SHALL be 1 for exactly one cycle, with redirect_pc = res_taken ? res_target : head.fallthru, using values captured at the resolve edge.
REQ-027 On the cycle after every valid resolve, whether correct or mispredicted, upd_en SHALL be 1 for one cycle and upd_taken SHALL equal the captured res_taken.
REQ-028 upd_en and upd_taken SHALL be 0 in all other cycles.
REQ-029 redirect_pc SHALL hold its last value when flush=0.
REQ-030 A res_valid with count=0 SHALL be ignored: no pop, no upd_en, no flush.
- It SHALL set err_underflow, which stays 1 until reset.
REQ-031 Latency SHALL be: resolve edge to flush/upd_en = 1 cycle; push to eligible-for-resolve = 1 cycle.
- A resolve in the same cycle as a push to an empty queue counts as underflow.
REQ-032 The block SHALL resolve strictly in order; only the head is ever compared.

Reset
REQ-033 While rst=1 at an edge, pointers and count SHALL be set to 0, and flush, upd_en, upd_taken and err_underflow SHALL be set to 0.
REQ-034 While rst=1 at an edge, redirect_pc SHALL be set to 0 and entry contents are don't-care.
REQ-035 rst SHALL override all simultaneous push/resolve activity.
- A mispredict in the cycle of reset SHALL produce no flush pulse afterwards.
REQ-036 After reset is released, push_ready SHALL be 1 in the first cycle.

Verification
REQ-037 Correct stream: push {1, 0x100, 0x44}, then resolve taken with target 0x100 -> upd_en=1 and upd_taken=1 next cycle, flush=0, count returns to 0.
REQ-038 Direction mispredict: push {0, 0x200, 0x84} and {1, 0x300, 0x90}; resolve taken with target 0x200 -> next cycle flush=1, redirect_pc=0x200, count=0, upd_taken=1.
REQ-039 Target mispredict plus not-taken redirect: head {1, 0x400, 0xA4}, resolve taken 0x408 -> redirect_pc=0x408.
- Then a fresh head {1, x, 0xB4} resolved not-taken -> redirect_pc=0xB4.
REQ-040 Full and wrap: push 4 entries -> push_ready=0 and count=4.
- A push+resolve in the same cycle SHALL leave the push refused.
- Then 10 alternating push/correct-resolve cycles SHALL keep FIFO order across pointer wrap.
REQ-041 Simultaneous mispredict and push: count=2, push_valid=1 in the same cycle as a mispredict resolve -> count=0 and the pushed entry is absent; push_ready=0 during the flush cycle.
REQ-042 Underflow and reset: res_valid with count=0 -> err_underflow=1, no upd_en; then assert rst during a mispredict resolve -> all outputs 0 next cycle, no flush.
